// File: rtl/delay_sum_beamformer.sv
// delay_sum_beamformer
//   Multi-channel delay-and-sum core. Each accepted frame carries one signed
//   sample per channel. Every channel is delayed by its own programmable
//   number of frames through a circular history buffer. The delayed samples
//   are then summed at full precision in a two-stage pipeline.
//
// Ports:
//   clk          rising-edge clock for all logic
//   reset        synchronous, active-high reset
//   sample_in    input frame, channel c at [c*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   sample_valid frame present on sample_in
//   sample_ready core accepts a frame this cycle
//   cfg_we       delay register write enable
//   cfg_channel  channel whose delay is written (out-of-range writes ignored)
//   cfg_delay    new delay in frames
//   sum_out      signed sum of the delayed samples (registered)
//   sum_valid    sum_out holds a result (registered)
//   sum_ready    downstream accepts sum_out
module delay_sum_beamformer #(
    parameter int NUM_CHANNELS = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int DEPTH        = 16,
    localparam int CW          = $clog2(NUM_CHANNELS),
    localparam int DW          = $clog2(DEPTH),
    localparam int SUM_WIDTH   = SAMPLE_WIDTH + CW,
    localparam int CFG_W       = (CW > 0) ? CW : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_in,
    input  logic                                 sample_valid,
    output logic                                 sample_ready,
    input  logic                                 cfg_we,
    input  logic [CFG_W-1:0]                     cfg_channel,
    input  logic [DW-1:0]                        cfg_delay,
    output logic [SUM_WIDTH-1:0]                 sum_out,
    output logic                                 sum_valid,
    input  logic                                 sum_ready
);

    logic                    advance_s;
    logic                    accept_s;
    logic                    cfg_hit_s;
    logic [DW-1:0]           wr_ptr_r;
    logic [DW-1:0]           delay_r   [NUM_CHANNELS];
    logic [SAMPLE_WIDTH-1:0] hist_r    [NUM_CHANNELS][DEPTH];
    logic [DW-1:0]           rd_addr_s [NUM_CHANNELS];
    logic [SAMPLE_WIDTH-1:0] tap_s     [NUM_CHANNELS];
    logic                    s1_valid_r;
    logic [SAMPLE_WIDTH-1:0] s1_data_r [NUM_CHANNELS];
    logic [SUM_WIDTH-1:0]    sum_s;
    logic [SUM_WIDTH-1:0]    sum_out_r;
    logic                    sum_valid_r;

    // The whole pipeline moves together; an empty or draining output lets it advance.
    assign advance_s    = ~sum_valid_r | sum_ready;
    assign sample_ready = advance_s & ~reset;
    assign accept_s     = sample_valid & sample_ready;
    // Widen by one bit so the range test stays meaningful for power-of-two channel counts.
    assign cfg_hit_s    = cfg_we & ({1'b0, cfg_channel} < (CFG_W+1)'(NUM_CHANNELS));

    assign sum_out   = sum_out_r;
    assign sum_valid = sum_valid_r;

    // Delayed sample selection: delay 0 bypasses memory, since that slot is written by this very frame.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            rd_addr_s[c] = wr_ptr_r - delay_r[c];
            if (delay_r[c] == {DW{1'b0}}) begin
                tap_s[c] = sample_in[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end else begin
                tap_s[c] = hist_r[c][rd_addr_s[c]];
            end
        end
    end

    // Full-precision adder tree input: sign-extend each staged sample and accumulate.
    always_comb begin
        sum_s = {SUM_WIDTH{1'b0}};
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sum_s = sum_s + {{CW{s1_data_r[c][SAMPLE_WIDTH-1]}}, s1_data_r[c]};
        end
    end

    // History buffer and write pointer; the pointer wraps naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {DW{1'b0}};
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    hist_r[c][d] <= {SAMPLE_WIDTH{1'b0}};
                end
            end
        end else if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + DW'(1'b1);
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                hist_r[c][wr_ptr_r] <= sample_in[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
    end

    // Per-channel delay registers; writes land at the edge, so a coincident frame still sees the old delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                delay_r[c] <= {DW{1'b0}};
            end
        end else if (cfg_hit_s) begin
            delay_r[cfg_channel] <= cfg_delay;
        end
    end

    // Two-stage pipeline: S1 stages the delayed samples, S2 registers their sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r  <= 1'b0;
            sum_valid_r <= 1'b0;
            sum_out_r   <= {SUM_WIDTH{1'b0}};
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                s1_data_r[c] <= {SAMPLE_WIDTH{1'b0}};
            end
        end else if (advance_s) begin
            s1_valid_r  <= accept_s;
            sum_valid_r <= s1_valid_r;
            if (accept_s) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    s1_data_r[c] <= tap_s[c];
                end
            end
            if (s1_valid_r) begin
                sum_out_r <= sum_s;
            end
        end
    end

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Self-checking bench for delay_sum_beamformer. A frame-history reference model
// predicts each sum as the plain arithmetic sum of frame[n - delay[c]] per channel
// (zero before reset); a scoreboard matches predictions against output handshakes.
module tb_delay_sum_beamformer;

    localparam int NC = 4;
    localparam int SW = 16;
    localparam int DP = 16;
    localparam int MAXF = 4096;

    logic              clk;
    logic              reset;
    logic [NC*SW-1:0]  sample_in;
    logic              sample_valid;
    logic              sample_ready;
    logic              cfg_we;
    logic [1:0]        cfg_channel;
    logic [3:0]        cfg_delay;
    logic [SW+1:0]     sum_out;
    logic              sum_valid;
    logic              sum_ready;

    int     total_cnt;
    int     bad_cnt;
    int     frames [0:MAXF-1][0:NC-1];
    int     nframes;
    int     dly [0:NC-1];
    longint exp_q [$];
    longint taken_q [$];
    bit     hold_pend;
    longint hold_sum;

    delay_sum_beamformer #(
        .NUM_CHANNELS(NC),
        .SAMPLE_WIDTH(SW),
        .DEPTH(DP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .cfg_we(cfg_we),
        .cfg_channel(cfg_channel),
        .cfg_delay(cfg_delay),
        .sum_out(sum_out),
        .sum_valid(sum_valid),
        .sum_ready(sum_ready)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input longint got, input longint exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_frame(input int a, input int b, input int c, input int d);
        int v [0:NC-1];
        logic [SW-1:0] s;
        v = '{a, b, c, d};
        for (int i = 0; i < NC; i++) begin
            s = v[i][SW-1:0];
            sample_in[i*SW +: SW] = s;
        end
    endtask

    task automatic set_random_frame();
        for (int i = 0; i < NC; i++) begin
            sample_in[i*SW +: SW] = SW'($urandom_range(0, 65535));
        end
    endtask

    // One clock cycle: observe at the falling edge, update model, then move past the rising edge.
    task automatic tick();
        longint got;
        longint e;
        int     idx;
        bit     exp_rdy;
        @(negedge clk);
        got = $signed(sum_out);
        exp_rdy = !reset && (!sum_valid || sum_ready);
        check_value("sample_ready", sample_ready, exp_rdy);
        if (hold_pend) begin
            check_value("hold_valid", sum_valid, 1);
            check_value("hold_sum", got, hold_sum);
        end
        if (reset) begin
            nframes = 0;
            for (int c = 0; c < NC; c++) dly[c] = 0;
            exp_q.delete();
            hold_pend = 1'b0;
        end else begin
            if (sum_valid && sum_ready) begin
                check_value("sum_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_value("sum", got, e);
                    taken_q.push_back(got);
                end
            end
            if (sample_valid && sample_ready && nframes < MAXF) begin
                for (int c = 0; c < NC; c++) begin
                    frames[nframes][c] = int'($signed(sample_in[c*SW +: SW]));
                end
                e = 0;
                for (int c = 0; c < NC; c++) begin
                    idx = nframes - dly[c];
                    if (idx >= 0) e += frames[idx][c];
                end
                exp_q.push_back(e);
                nframes++;
            end
            if (cfg_we && cfg_channel < NC) dly[cfg_channel] = int'(cfg_delay);
            hold_pend = sum_valid && !sum_ready;
            hold_sum = got;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        sample_valid = 1'b0;
        cfg_we = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic drain();
        sample_valid = 1'b0;
        cfg_we = 1'b0;
        sum_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        check_value("drain_empty", exp_q.size(), 0);
    endtask

    task automatic write_cfg(input int ch, input int d);
        cfg_we = 1'b1;
        cfg_channel = 2'(ch);
        cfg_delay = 4'(d);
        sample_valid = 1'b0;
        tick();
        cfg_we = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  exp2 [0:5];
        bit  low_seen;
        longint ev;
        clk = 1'b0;
        reset = 1'b1;
        sample_valid = 1'b0;
        sample_in = '0;
        cfg_we = 1'b0;
        cfg_channel = 2'd0;
        cfg_delay = 4'd0;
        sum_ready = 1'b1;
        total_cnt = 0;
        bad_cnt = 0;
        nframes = 0;
        hold_pend = 1'b0;
        hold_sum = 0;
        for (int c = 0; c < NC; c++) dly[c] = 0;

        // Reset state.
        do_reset(3);
        check_value("rst_sum_valid", sum_valid, 0);
        check_value("rst_sum_out", $signed(sum_out), 0);
        check_value("rst_ready", sample_ready, 1);

        // Zero delays, latency and the full-scale negative sum.
        taken_q.delete();
        set_frame(1, 2, 3, 4);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check_value("lat1_valid", sum_valid, 0);
        tick();
        check_value("lat2_valid", sum_valid, 1);
        check_value("lat2_sum", $signed(sum_out), 10);
        set_frame(-32768, -32768, -32768, -32768);
        sample_valid = 1'b1;
        tick();
        drain();
        check_value("t1_count", taken_q.size(), 2);
        if (taken_q.size() == 2) begin
            check_value("t1_sum0", taken_q[0], 10);
            check_value("t1_sum1", taken_q[1], -131072);
        end

        // Delays {0,1,2,3}: each sum adds the current value and up to three earlier ones.
        do_reset(1);
        for (int c = 0; c < NC; c++) write_cfg(c, c);
        taken_q.delete();
        for (int k = 0; k < 6; k++) begin
            set_frame(k + 1, k + 1, k + 1, k + 1);
            sample_valid = 1'b1;
            tick();
        end
        drain();
        exp2 = '{1, 3, 6, 10, 14, 18};
        check_value("t2_count", taken_q.size(), 6);
        for (int k = 0; k < 6 && k < taken_q.size(); k++) begin
            check_value("t2_sum", taken_q[k], exp2[k]);
        end

        // Maximum delay across two pointer wraps.
        do_reset(1);
        write_cfg(2, DP - 1);
        taken_q.delete();
        for (int n = 0; n < 40; n++) begin
            set_frame(0, 0, n, 0);
            sample_valid = 1'b1;
            tick();
        end
        drain();
        check_value("t3_count", taken_q.size(), 40);
        for (int n = 0; n < 40 && n < taken_q.size(); n++) begin
            ev = (n >= DP - 1) ? n - (DP - 1) : 0;
            check_value("t3_sum", taken_q[n], ev);
        end

        // Backpressure: output stalled while frames keep arriving.
        sum_ready = 1'b0;
        sample_valid = 1'b1;
        low_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_random_frame();
            if (!sample_ready) low_seen = 1'b1;
            tick();
        end
        check_value("bp_ready_drop", low_seen, 1);
        drain();

        // Config write coincident with an accept uses the old delay.
        do_reset(1);
        taken_q.delete();
        set_frame(0, 5, 0, 0);
        sample_valid = 1'b1;
        cfg_we = 1'b1;
        cfg_channel = 2'd1;
        cfg_delay = 4'd2;
        tick();
        cfg_we = 1'b0;
        set_frame(0, 7, 0, 0);
        tick();
        set_frame(0, 9, 0, 0);
        tick();
        drain();
        check_value("t5_count", taken_q.size(), 3);
        if (taken_q.size() == 3) begin
            check_value("t5_old_delay", taken_q[0], 5);
            check_value("t5_new_delay", taken_q[1], 0);
            check_value("t5_history", taken_q[2], 5);
        end

        // Reset with two frames in flight.
        do_reset(1);
        write_cfg(0, 1);
        set_frame(100, 100, 100, 100);
        sample_valid = 1'b1;
        tick();
        tick();
        sample_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_value("t6_valid_after_rst", sum_valid, 0);
        taken_q.delete();
        set_frame(1, 2, 3, 4);
        sample_valid = 1'b1;
        tick();
        drain();
        check_value("t6_count", taken_q.size(), 1);
        if (taken_q.size() == 1) check_value("t6_sum", taken_q[0], 10);

        // Randomized traffic with config writes, backpressure and rare resets.
        do_reset(1);
        for (int i = 0; i < 800; i++) begin
            sample_valid = ($urandom_range(0, 3) != 0);
            set_random_frame();
            sum_ready = ($urandom_range(0, 3) != 0);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_channel = 2'($urandom_range(0, 3));
            cfg_delay = 4'($urandom_range(0, DP - 1));
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
